// File: rtl/divider_sequencer_pkg.sv
// Shared definitions for the divider sequencer: FSM state encoding and
// default operand width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam int DEFAULT_N = 8;

  // Quotient reported for a divide-by-zero at the default width
  localparam logic [DEFAULT_N-1:0] DZ_QUOT = '1;

endpackage

// File: rtl/divider_sequencer_cycle_timer.sv
// Watchdog cycle counter with synchronous clear and a terminal-count flag
// that fires when the count reaches TIMEOUT-1.
module cycle_timer #(
  parameter int TW      = 6,
  parameter int TIMEOUT = 32
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [TW-1:0] count;

  always_ff @(posedge Clock) begin
    if (!Resetn || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/divider_sequencer.sv
// Control stage in front of the restoring divider: accepts operand pairs,
// strobes the divider, collects Q/R and holds the result for the consumer.
module divider_sequencer
  import div_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int TIMEOUT = 32,
  parameter int TW      = 6
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         s,
  output logic         LA,
  output logic         EB,
  output logic [N-1:0] DataA,
  output logic [N-1:0] DataB,
  input  logic [N-1:0] Q,
  input  logic [N-1:0] R,
  input  logic         Done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_q,
  output logic [N-1:0] out_r,
  output logic         out_dz,
  output logic         out_err
);

  state_t state;
  logic   timerClear;
  logic   timerEnable;
  logic   timerTc;

  assign in_ready    = Resetn && (state == IDLE);
  assign timerClear  = (state == LOAD);
  assign timerEnable = (state == RUN);

  cycle_timer #(
    .TW     (TW),
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .Clock (Clock),
    .Resetn(Resetn),
    .clear (timerClear),
    .enable(timerEnable),
    .tc    (timerTc)
  );

  // Strobes are raised on the IDLE->LOAD edge so they are high for exactly
  // the LOAD cycle; a zero divisor bypasses the divider entirely.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= IDLE;
      s         <= 1'b0;
      LA        <= 1'b0;
      EB        <= 1'b0;
      DataA     <= '0;
      DataB     <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_dz    <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      s  <= 1'b0;
      LA <= 1'b0;
      EB <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            DataA <= in_a;
            DataB <= in_b;
            if (in_b == '0) begin
              state     <= RESULT;
              out_valid <= 1'b1;
              out_q     <= {N{1'b1}};
              out_r     <= in_a;
              out_dz    <= 1'b1;
              out_err   <= 1'b0;
            end else begin
              state <= LOAD;
              s     <= 1'b1;
              LA    <= 1'b1;
              EB    <= 1'b1;
            end
          end
        end
        LOAD: begin
          state <= RUN;
        end
        RUN: begin
          // Done wins over a timeout landing in the same cycle
          if (Done) begin
            state     <= RESULT;
            out_valid <= 1'b1;
            out_q     <= Q;
            out_r     <= R;
            out_dz    <= 1'b0;
            out_err   <= 1'b0;
          end else if (timerTc) begin
            state     <= RESULT;
            out_valid <= 1'b1;
            out_q     <= '0;
            out_r     <= '0;
            out_dz    <= 1'b0;
            out_err   <= 1'b1;
          end
        end
        RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_sequencer.sv
// Self-checking bench for divider_sequencer with a behavioural divider stub
// and an arithmetic reference model.
module tb_divider_sequencer;

  localparam int N       = 8;
  localparam int TIMEOUT = 32;

  logic         Clock = 1'b0;
  logic         Resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic         s, LA, EB;
  logic [N-1:0] DataA, DataB;
  logic [N-1:0] Q, R;
  logic         Done;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_q, out_r;
  logic         out_dz, out_err;

  int nChecks = 0;
  int nFails  = 0;
  int strobeCount = 0;

  int           stubLatency = 5;
  bit           stubNever = 1'b0;
  int           stubCnt = 0;
  logic [N-1:0] stubA = '0, stubB = '1;
  logic         stubDone = 1'b0;
  logic [N-1:0] stubQ = '0, stubR = '0;

  assign Done = stubDone;
  assign Q    = stubQ;
  assign R    = stubR;

  always #5 Clock = ~Clock;

  divider_sequencer #(.N(N), .TIMEOUT(TIMEOUT), .TW(6)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .s(s), .LA(LA), .EB(EB), .DataA(DataA), .DataB(DataB),
    .Q(Q), .R(R), .Done(Done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_dz(out_dz), .out_err(out_err)
  );

  // Divider stand-in: latches operands on the load strobe and pulses Done
  // stubLatency cycles later; Q/R carry noise whenever Done is low.
  always @(posedge Clock) begin
    stubDone <= 1'b0;
    stubQ    <= N'($urandom);
    stubR    <= N'($urandom);
    if (s && LA) begin
      stubA   <= DataA;
      stubB   <= DataB;
      stubCnt <= stubNever ? 0 : stubLatency;
    end else if (stubCnt != 0) begin
      stubCnt <= stubCnt - 1;
      if (stubCnt == 1) begin
        stubDone <= 1'b1;
        stubQ    <= stubA / stubB;
        stubR    <= stubA % stubB;
      end
    end
  end

  always @(posedge Clock) begin
    if (s || LA || EB) strobeCount <= strobeCount + 1;
  end

  function automatic void refModel(input logic [N-1:0] a, input logic [N-1:0] b,
                                   output logic [N-1:0] q, output logic [N-1:0] r,
                                   output logic dz);
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge Clock);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 10 && !in_ready; i++) @(negedge Clock);
    @(negedge Clock);
    in_valid = 1'b0;
  endtask

  task automatic waitOutValid(input int maxCyc, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < maxCyc) begin
      @(negedge Clock);
      cyc++;
      if (out_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    Resetn = 1'b0;
    repeat (3) @(negedge Clock);
    nChecks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || {s, LA, EB} !== 3'b000) begin
      nFails++;
      $display("[TB] FAIL reset_ctrl: in_ready=%b out_valid=%b s/LA/EB=%b, expected 0 0 000",
               in_ready, out_valid, {s, LA, EB});
    end
    nChecks++;
    if (DataA !== 0 || DataB !== 0 || out_q !== 0 || out_r !== 0 || out_dz !== 0 || out_err !== 0) begin
      nFails++;
      $display("[TB] FAIL reset_data: DataA=%0d DataB=%0d q=%0d r=%0d dz=%b err=%b, expected all 0",
               DataA, DataB, out_q, out_r, out_dz, out_err);
    end
    Resetn = 1'b1;
    @(negedge Clock);
    nChecks++;
    if (in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL reset_idle: in_ready=%b, expected 1", in_ready);
    end
  endtask

  task automatic test_transaction(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input int lat, input int hold);
    logic [N-1:0] q, r;
    logic dz;
    int cyc, s0;
    bit ok;
    stubLatency = lat;
    out_ready = 1'b0;
    refModel(a, b, q, r, dz);
    s0 = strobeCount;
    applyStimulus(a, b);
    if (b != 0) begin
      nChecks++;
      if ({s, LA, EB} !== 3'b111 || DataA !== a || DataB !== b) begin
        nFails++;
        $display("[TB] FAIL load: s/LA/EB=%b DataA=%0d DataB=%0d, expected 111 %0d %0d",
                 {s, LA, EB}, DataA, DataB, a, b);
      end
      waitOutValid(TIMEOUT + 4, cyc, ok);
      nChecks++;
      if (!ok || cyc != lat + 2) begin
        nFails++;
        $display("[TB] FAIL latency: out_valid after %0d cycles (seen=%0b), expected %0d",
                 cyc, ok, lat + 2);
      end
    end else begin
      nChecks++;
      if (out_valid !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL dz_latency: out_valid=%b one cycle after accept, expected 1", out_valid);
      end
    end
    nChecks++;
    if (out_q !== q || out_r !== r || out_dz !== dz || out_err !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL result %0d/%0d: q=%0d r=%0d dz=%b err=%b, expected q=%0d r=%0d dz=%b err=0",
               a, b, out_q, out_r, out_dz, out_err, q, r, dz);
    end
    nChecks++;
    if (strobeCount - s0 != ((b != 0) ? 1 : 0)) begin
      nFails++;
      $display("[TB] FAIL strobes %0d/%0d: %0d strobe cycles, expected %0d",
               a, b, strobeCount - s0, (b != 0) ? 1 : 0);
    end
    for (int i = 0; i < hold; i++) begin
      nChecks++;
      if (out_valid !== 1'b1 || out_q !== q || out_r !== r || in_ready !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL hold[%0d]: valid=%b q=%0d r=%0d in_ready=%b, expected 1 %0d %0d 0",
                 i, out_valid, out_q, out_r, in_ready, q, r);
      end
      @(negedge Clock);
    end
    out_ready = 1'b1;
    @(negedge Clock);
    nChecks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_timeout;
    int cyc, s0;
    bit ok;
    stubNever = 1'b1;
    out_ready = 1'b0;
    s0 = strobeCount;
    applyStimulus(8'd50, 8'd3);
    waitOutValid(TIMEOUT + 8, cyc, ok);
    nChecks++;
    if (!ok || cyc != TIMEOUT + 1) begin
      nFails++;
      $display("[TB] FAIL timeout_cycles: out_valid after %0d cycles (seen=%0b), expected %0d",
               cyc, ok, TIMEOUT + 1);
    end
    nChecks++;
    if (out_err !== 1'b1 || out_q !== 0 || out_r !== 0 || out_dz !== 1'b0 || strobeCount - s0 != 1) begin
      nFails++;
      $display("[TB] FAIL timeout_result: err=%b q=%0d r=%0d dz=%b strobes=%0d, expected 1 0 0 0 1",
               out_err, out_q, out_r, out_dz, strobeCount - s0);
    end
    out_ready = 1'b1;
    @(negedge Clock);
    nChecks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL timeout_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
    stubNever = 1'b0;
    test_transaction(8'd77, 8'd4, 3, 0);
  endtask

  task automatic test_reset_mid_run;
    bit seenValid;
    stubLatency = 15;
    out_ready = 1'b1;
    applyStimulus(8'd90, 8'd6);
    repeat (3) @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    nChecks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || {s, LA, EB} !== 3'b000 || DataA !== 0) begin
      nFails++;
      $display("[TB] FAIL midrun_reset: in_ready=%b out_valid=%b s/LA/EB=%b DataA=%0d, expected 0 0 000 0",
               in_ready, out_valid, {s, LA, EB}, DataA);
    end
    Resetn = 1'b1;
    seenValid = 1'b0;
    repeat (25) begin
      @(negedge Clock);
      if (out_valid !== 1'b0) seenValid = 1'b1;
    end
    nChecks++;
    if (seenValid || in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL stale_done: out_valid seen=%0b in_ready=%b, expected 0 1", seenValid, in_ready);
    end
  endtask

  task automatic test_random;
    logic [N-1:0] a, b;
    for (int k = 0; k < 20; k++) begin
      a = N'($urandom_range(0, 255));
      b = ($urandom_range(0, 4) == 0) ? 8'd0 : N'($urandom_range(1, 255));
      test_transaction(a, b, $urandom_range(1, 20), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset;
    test_transaction(8'd30, 8'd5, 4, 0);
    test_transaction(8'd200, 8'd7, 9, 0);
    test_transaction(8'd17, 8'd0, 1, 0);
    test_transaction(8'd100, 8'd9, 6, 5);
    test_timeout;
    test_reset_mid_run;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
